// File: rtl/idct_transpose4.sv
// 4x4 ping-pong transpose between IDCT stages: rows in, columns out, first column the cycle after the last row.
// out_ready stalls only the read side; IDCT_TRANSPOSE_CLIP_EN saturates inputs to [CLIP_MIN, CLIP_MAX] before storage.
module idct_transpose4 #(
  parameter int W        = 25,
  parameter int CLIP_MIN = -32768,
  parameter int CLIP_MAX = 32767
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] d_in_1,
  input  logic signed [W-1:0] d_in_2,
  input  logic signed [W-1:0] d_in_3,
  input  logic signed [W-1:0] d_in_4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic signed [W-1:0] d_out_1,
  output logic signed [W-1:0] d_out_2,
  output logic signed [W-1:0] d_out_3,
  output logic signed [W-1:0] d_out_4
);

`ifdef IDCT_TRANSPOSE_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  localparam logic signed [W-1:0] LO = W'(CLIP_MIN);
  localparam logic signed [W-1:0] HI = W'(CLIP_MAX);

  function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = v;
    if (CLIP_ON) begin
      if (v > HI) r = HI;
      else if (v < LO) r = LO;
    end
    return r;
  endfunction

  logic signed [W-1:0] mem [2][4][4];
  logic signed [W-1:0] wdat [4];
  logic       wbank, rbank;
  logic [1:0] wrow, rcol;
  logic [1:0] full, full_nxt;
  logic       wr_fire, rd_fire;

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_last  = out_valid && (rcol == 2'd3);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign d_out_1 = mem[rbank][0][rcol];
  assign d_out_2 = mem[rbank][1][rcol];
  assign d_out_3 = mem[rbank][2][rcol];
  assign d_out_4 = mem[rbank][3][rcol];

  always_comb begin
    wdat[0] = sat(d_in_1);
    wdat[1] = sat(d_in_2);
    wdat[2] = sat(d_in_3);
    wdat[3] = sat(d_in_4);
  end

  // A write can only target an empty bank and a read a full one, so the two updates never collide.
  always_comb begin
    full_nxt = full;
    if (rd_fire && rcol == 2'd3) full_nxt[rbank] = 1'b0;
    if (wr_fire && wrow == 2'd3) full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mem[b][r][c] <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wrow  <= 2'd0;
      rcol  <= 2'd0;
      full  <= 2'b00;
    end else begin
      if (wr_fire) begin
        for (int c = 0; c < 4; c++)
          mem[wbank][wrow][c] <= wdat[c];
        wrow <= wrow + 2'd1;
        if (wrow == 2'd3) wbank <= ~wbank;
      end
      if (rd_fire) begin
        rcol <= rcol + 2'd1;
        if (rcol == 2'd3) rbank <= ~rbank;
      end
      full <= full_nxt;
    end
  end

endmodule

// File: tb/tb_idct_transpose4.sv
// Bench for idct_transpose4: block-level transpose model plus directed literal checks.
module tb_idct_transpose4;
  localparam int W = 25;
`ifdef IDCT_TRANSPOSE_CLIP_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = 40000;
  localparam int EXP_NEG = -40000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] d_in_1 = '0, d_in_2 = '0, d_in_3 = '0, d_in_4 = '0;
  logic in_ready, out_valid, out_last;
  logic signed [W-1:0] d_out_1, d_out_2, d_out_3, d_out_4;

  idct_transpose4 #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int d[4]; bit last; } col_t;
  col_t colq[$];
  int   rows[4][4];
  int   nrows = 0;
  bit   armed = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
`ifdef IDCT_TRANSPOSE_CLIP_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  // Every complete block not yet fully read occupies one bank.
  function automatic int pending();
    return (colq.size() + 3) / 4;
  endfunction

  always @(negedge clk) begin : monitor
    int p;
    bit in_fire, out_fire;
    col_t e;
    p = pending();
    if (armed) begin
      chk("in_ready", int'(in_ready), (p < 2) ? 1 : 0);
      chk("out_valid", int'(out_valid), (p > 0) ? 1 : 0);
      if (p > 0) begin
        chk("d_out_1", int'(d_out_1), colq[0].d[0]);
        chk("d_out_2", int'(d_out_2), colq[0].d[1]);
        chk("d_out_3", int'(d_out_3), colq[0].d[2]);
        chk("d_out_4", int'(d_out_4), colq[0].d[3]);
        chk("out_last", int'(out_last), int'(colq[0].last));
      end else begin
        chk("out_last_idle", int'(out_last), 0);
      end
    end
    if (!reset) begin
      colq.delete();
      nrows = 0;
      armed = 1'b1;
    end else begin
      in_fire  = in_valid && (p < 2);
      out_fire = out_ready && (p > 0);
      if (out_fire) void'(colq.pop_front());
      if (in_fire) begin
        rows[nrows][0] = sat(int'(d_in_1));
        rows[nrows][1] = sat(int'(d_in_2));
        rows[nrows][2] = sat(int'(d_in_3));
        rows[nrows][3] = sat(int'(d_in_4));
        nrows++;
        if (nrows == 4) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) e.d[r] = rows[r][c];
            e.last = (c == 3);
            colq.push_back(e);
          end
          nrows = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input int a, input int b, input int c, input int d, output int waits);
    bit ok;
    waits = 0;
    in_valid = 1'b1;
    d_in_1 = a[W-1:0];
    d_in_2 = b[W-1:0];
    d_in_3 = c[W-1:0];
    d_in_4 = d[W-1:0];
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
      waits++;
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (colq.size() == 0) break;
    end
    if (colq.size() != 0) chk("drain_timeout", colq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int w, tot;
    // reset held with in_valid asserted
    reset = 1'b0;
    in_valid = 1'b1;
    d_in_1 = 25'sd7; d_in_2 = 25'sd8; d_in_3 = 25'sd9; d_in_4 = 25'sd10;
    out_ready = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_d_out_1", int'(d_out_1), 0);
    chk("rst_d_out_4", int'(d_out_4), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst_nothing_stored", int'(out_valid), 0);
    @(posedge clk); #1;

    // single block
    for (int r = 0; r < 4; r++) send_row(4*r+1, 4*r+2, 4*r+3, 4*r+4, w);
    @(negedge clk);
    chk("sb_valid", int'(out_valid), 1);
    chk("sb_c0_1", int'(d_out_1), 1);
    chk("sb_c0_2", int'(d_out_2), 5);
    chk("sb_c0_3", int'(d_out_3), 9);
    chk("sb_c0_4", int'(d_out_4), 13);
    chk("sb_c0_last", int'(out_last), 0);
    repeat (3) @(negedge clk);
    chk("sb_c3_1", int'(d_out_1), 4);
    chk("sb_c3_4", int'(d_out_4), 16);
    chk("sb_c3_last", int'(out_last), 1);
    drain();

    // streaming: 8 blocks back-to-back
    tot = 0;
    for (int b = 0; b < 8; b++)
      for (int r = 0; r < 4; r++) begin
        send_row(b*64 + r*4 + 1, -(b*64 + r*4 + 2), b*64 + r*4 + 3, -(b*64 + r*4 + 4), w);
        tot += w;
      end
    chk("stream_stalls", tot, 0);
    drain();

    // back-pressure: three blocks against a stalled reader
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++)
          for (int r = 0; r < 4; r++)
            send_row(1000*(k+1) + r*4, 1000*(k+1) + r*4 + 1, 1000*(k+1) + r*4 + 2, 1000*(k+1) + r*4 + 3, w);
      end
      begin
        cyc(10);
        @(negedge clk);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_c0_1", int'(d_out_1), 1000);
        chk("bp_c0_4", int'(d_out_4), 1012);
        @(posedge clk); #1;
        cyc(3);
        @(negedge clk);
        chk("bp_hold_1", int'(d_out_1), 1000);
        chk("bp_hold_2", int'(d_out_2), 1004);
        chk("bp_hold_3", int'(d_out_3), 1008);
        chk("bp_hold_4", int'(d_out_4), 1012);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
      end
    join
    drain();

    // saturation path
    send_row(40000, -40000, 32767, -32768, w);
    for (int r = 0; r < 3; r++) send_row(0, 0, 0, 0, w);
    @(negedge clk);
    chk("clip_c0", int'(d_out_1), EXP_POS);
    @(negedge clk);
    chk("clip_c1", int'(d_out_1), EXP_NEG);
    @(negedge clk);
    chk("clip_c2", int'(d_out_1), 32767);
    @(negedge clk);
    chk("clip_c3", int'(d_out_1), -32768);
    drain();

    // reset in the middle of a block
    send_row(99, 98, 97, 96, w);
    send_row(95, 94, 93, 92, w);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    for (int r = 0; r < 4; r++) send_row(200 + 4*r, 201 + 4*r, 202 + 4*r, 203 + 4*r, w);
    @(negedge clk);
    chk("mr_valid", int'(out_valid), 1);
    chk("mr_c0_1", int'(d_out_1), 200);
    chk("mr_c0_2", int'(d_out_2), 204);
    chk("mr_c0_4", int'(d_out_4), 212);
    drain();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
